pid_output_pwm: RTL and testbench

- Downstream stage of the P, I and D contribution blocks.
- Sums the three signed contributions and saturates the result to the actuator range.
- Converts the result into a glitch-free PWM waveform. Duty cycle changes only at period boundaries.
- Emits a once-per-period tick that the top level may use to pace controller sampling.

---
 rtl/pid_output_pwm.sv | 59 +++++
 tb/tb_pid_output_pwm.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pid_output_pwm.sv
// pid_output_pwm: sums P/I/D contributions, saturates to the actuator range and drives a glitch-free PWM.
//   clk, rst_n (sync, active-low)
//   ena                           : gates the sum/saturate pipeline only
//   p_contrib/i_contrib/d_contrib : signed W-bit contributions
//   u_out, sat_hi, sat_lo         : saturated output and clip flags (2 enabled edges latency)
//   pwm_out, period_tick          : PWM drive (period 2^W) and once-per-period pulse
module pid_output_pwm #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [W-1:0] p_contrib,
    input  logic [W-1:0] i_contrib,
    input  logic [W-1:0] d_contrib,
    output logic [W-1:0] u_out,
    output logic         sat_hi,
    output logic         sat_lo,
    output logic         pwm_out,
    output logic         period_tick
);
    localparam logic signed [W+1:0] MAX_V = (W+2)'(2 ** (W - 1) - 1);
    localparam logic signed [W+1:0] MIN_V = -(W+2)'(2 ** (W - 1));
    logic signed [W+1:0] sum_r;
    logic [W-1:0] cnt, duty_act, u_next;
    logic hi, lo;
    always_comb begin
        hi = sum_r > MAX_V;
        lo = sum_r < MIN_V;
        u_next = hi ? {1'b0, {(W-1){1'b1}}} : lo ? {1'b1, {(W-1){1'b0}}} : sum_r[W-1:0];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r       <= '0;
            u_out       <= '0;
            sat_hi      <= 1'b0;
            sat_lo      <= 1'b0;
            cnt         <= '0;
            duty_act    <= {1'b1, {(W-1){1'b0}}};
            pwm_out     <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            if (ena) begin
                sum_r  <= {{2{p_contrib[W-1]}}, p_contrib} + {{2{i_contrib[W-1]}}, i_contrib}
                        + {{2{d_contrib[W-1]}}, d_contrib};
                u_out  <= u_next;
                sat_hi <= hi;
                sat_lo <= lo;
            end
            cnt <= cnt + 1'b1;
            // duty only reloads at the wrap so the waveform never glitches mid-period;
            // inverting the MSB maps two's complement to offset binary
            if (cnt == '1)
                duty_act <= {~u_out[W-1], u_out[W-2:0]};
            pwm_out     <= cnt < duty_act;
            period_tick <= cnt == '1;
        end
    end
endmodule

// File: tb/tb_pid_output_pwm.sv
// tb_pid_output_pwm: directed bench with a cycle model and hand-computed duty/latency checks.
module tb_pid_output_pwm;
    localparam int W = 6;
    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
    logic [W-1:0] p_contrib = '0, i_contrib = '0, d_contrib = '0, u_out;
    logic sat_hi, sat_lo, pwm_out, period_tick;
    int checks = 0, failures = 0;
    int m_sum = 0, m_u = 0, m_hi = 0, m_lo = 0, m_cnt = 0, m_duty = 32, m_pwm = 0, m_tick = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    pid_output_pwm #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .p_contrib(p_contrib), .i_contrib(i_contrib), .d_contrib(d_contrib),
        .u_out(u_out), .sat_hi(sat_hi), .sat_lo(sat_lo),
        .pwm_out(pwm_out), .period_tick(period_tick)
    );

    function automatic int clamp(int v);
        return v > 31 ? 31 : (v < -32 ? -32 : v);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: integer arithmetic from the behavioural rules, evaluated on pre-edge values
    always @(posedge clk) begin
        int su, uu, cu, du;
        armed = 1'b1;
        if (!rst_n) begin
            m_sum = 0; m_u = 0; m_hi = 0; m_lo = 0;
            m_cnt = 0; m_duty = 32; m_pwm = 0; m_tick = 0;
        end else begin
            su = m_sum; uu = m_u; cu = m_cnt; du = m_duty;
            if (ena) begin
                m_sum = int'($signed(p_contrib)) + int'($signed(i_contrib)) + int'($signed(d_contrib));
                m_u  = clamp(su);
                m_hi = int'(su > 31);
                m_lo = int'(su < -32);
            end
            m_pwm  = int'(cu < du);
            m_tick = int'(cu == 63);
            if (cu == 63) m_duty = uu + 32;
            m_cnt = (cu + 1) % 64;
        end
    end

    always @(negedge clk) if (armed) begin
        chk("u_out", int'($signed(u_out)), m_u);
        chk("sat_hi", int'(sat_hi), m_hi);
        chk("sat_lo", int'(sat_lo), m_lo);
        chk("pwm_out", int'(pwm_out), m_pwm);
        chk("period_tick", int'(period_tick), m_tick);
    end

    task automatic set_in(int p, int i, int d, logic e);
        p_contrib = W'(p); i_contrib = W'(i); d_contrib = W'(d); ena = e;
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!period_tick && n < 130);
        if (!period_tick) begin
            checks++; failures++;
            $display("FAIL %s: no period_tick within %0d cycles", name, n);
        end
    endtask

    task automatic wait_cnt(int c);
        int n = 0;
        do begin @(negedge clk); n++; end while (m_cnt != c && n < 130);
        if (m_cnt != c) begin
            checks++; failures++;
            $display("FAIL wait_cnt: model count %0d never reached %0d", m_cnt, c);
        end
    endtask

    task automatic first_tick(string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!period_tick && n < 200);
        chk(name, n, 64);
    endtask

    // called at a tick negedge: counts high cycles over the following full period
    task automatic count_high(string name, int exp);
        int h = 0;
        for (int k = 0; k < 64; k++) begin @(negedge clk); h += int'(pwm_out); end
        chk(name, h, exp);
    endtask

    initial begin
        int h;
        step(3);
        chk("rst_u", int'(u_out), 0);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_tick", int'(period_tick), 0);
        rst_n = 1'b1;
        first_tick("first_tick_delay");
        count_high("reset_duty", 32);

        set_in(5, -3, 10, 1'b1);
        step(2);
        chk("nominal_u", int'($signed(u_out)), 12);
        chk("nominal_flags", int'({sat_hi, sat_lo}), 0);
        wait_tick("nominal");
        count_high("nominal_duty", 44);

        set_in(31, 31, 31, 1'b1);
        step(2);
        chk("sat_hi_u", int'($signed(u_out)), 31);
        chk("sat_hi_flag", int'(sat_hi), 1);
        wait_tick("sat_hi");
        count_high("sat_hi_duty", 63);

        set_in(-32, -32, -32, 1'b1);
        step(2);
        chk("sat_lo_u", int'($signed(u_out)), -32);
        chk("sat_lo_flags", int'({sat_hi, sat_lo}), 1);
        wait_tick("sat_lo");
        count_high("sat_lo_duty", 0);

        set_in(0, 0, 0, 1'b1);
        wait_tick("mid_setup");
        wait_tick("mid_start");
        h = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            h += int'(pwm_out);
            if (k == 18) set_in(20, 0, 0, 1'b1);
        end
        chk("mid_period_duty", h, 32);
        chk("mid_u", int'($signed(u_out)), 20);
        count_high("after_mid_duty", 52);

        set_in(1, 1, 1, 1'b0);
        step(5);
        chk("ena_hold_u", int'($signed(u_out)), 20);
        set_in(7, 0, 0, 1'b1);
        step(1);
        ena = 1'b0;
        step(3);
        chk("ena_pulse1_u", int'($signed(u_out)), 20);
        set_in(3, 3, 3, 1'b0);
        step(3);
        ena = 1'b1;
        step(1);
        ena = 1'b0;
        step(1);
        chk("ena_pulse2_u", int'($signed(u_out)), 7);

        set_in(20, 0, 0, 1'b1);
        step(2);
        wait_tick("rst_mid_setup");
        wait_cnt(40);
        chk("pre_rst_pwm", int'(pwm_out), 1);
        chk("pre_rst_u", int'($signed(u_out)), 20);
        rst_n = 1'b0;
        ena = 1'b0;
        step(1);
        chk("mid_rst_u", int'(u_out), 0);
        chk("mid_rst_pwm", int'(pwm_out), 0);
        rst_n = 1'b1;
        first_tick("mid_rst_first_tick");
        count_high("mid_rst_duty", 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
